// File: rtl/enc_ctrl.sv
// Systematic dual-diagonal parity encoder with valid/ack handshake.
// One parity bit is accumulated per cycle; the codeword is held until acked.
module enc_ctrl #(
   parameter int MSG_LEN = 4,
   parameter int CHECK_NUM = 4,
   parameter int CODE_LEN = MSG_LEN + CHECK_NUM,
   parameter logic [CHECK_NUM*MSG_LEN-1:0] H_MSG =
      {4'b1001, 4'b1100, 4'b0110, 4'b0011}
) (
   input  logic                clk,
   input  logic                xrst,
   input  logic [MSG_LEN-1:0]  i_data,
   input  logic                i_val,
   output logic                o_rdy,
   output logic [CODE_LEN-1:0] o_data,
   output logic                o_val,
   input  logic                i_ack,
   output logic [7:0]          o_count
);

   localparam int CW = (CHECK_NUM > 1) ? $clog2(CHECK_NUM) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [MSG_LEN-1:0]   msg_q, msg_d;
   logic [CHECK_NUM-1:0] par_q, par_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [7:0]           ocnt_q, ocnt_d;

   logic [MSG_LEN-1:0]   row;
   logic                 p_prev;
   logic                 s_bit;
   logic                 p_new;
   logic                 last;

   // Select check row j and the previously written parity bit p_(j-1).
   always_comb begin
      row    = '0;
      p_prev = 1'b0;
      for (int j = 0; j < CHECK_NUM; j++) begin
         if (cnt_q == CW'(j)) begin
            row = H_MSG[j*MSG_LEN +: MSG_LEN];
         end
      end
      for (int j = 1; j < CHECK_NUM; j++) begin
         if (cnt_q == CW'(j)) begin
            p_prev = par_q[j-1];
         end
      end
      s_bit = ^(msg_q & row);
      p_new = p_prev ^ s_bit;
      last  = (cnt_q == CW'(CHECK_NUM - 1));
   end

   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      par_d   = par_q;
      cnt_d   = cnt_q;
      ocnt_d  = ocnt_q;
      case (state_q)
         S_IDLE: begin
            if (i_val) begin
               msg_d   = i_data;
               par_d   = '0;
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            for (int j = 0; j < CHECK_NUM; j++) begin
               if (cnt_q == CW'(j)) begin
                  par_d[j] = p_new;
               end
            end
            if (last) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            if (i_ack) begin
               ocnt_d  = ocnt_q + 8'd1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state_q <= S_IDLE;
         msg_q   <= '0;
         par_q   <= '0;
         cnt_q   <= '0;
         ocnt_q  <= '0;
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         par_q   <= par_d;
         cnt_q   <= cnt_d;
         ocnt_q  <= ocnt_d;
      end
   end

   assign o_rdy   = (state_q == S_IDLE);
   assign o_val   = (state_q == S_DONE);
   assign o_data  = {par_q, msg_q};
   assign o_count = ocnt_q;

endmodule

// File: tb/tb_enc_ctrl.sv
// Self-checking bench for enc_ctrl: vector table, scoreboard queue,
// handshake corner cases, reset abort and a 256-word random run.
module tb_enc_ctrl;

   logic       clk = 1'b0;
   logic       xrst;
   logic [3:0] i_data;
   logic       i_val;
   logic       o_rdy;
   logic [7:0] o_data;
   logic       o_val;
   logic       i_ack;
   logic [7:0] o_count;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_cnt = 8'd0;
   logic [7:0] sb[$];

   typedef struct {
      logic [3:0] data;
      logic [7:0] code;
   } vec_t;

   vec_t tbl[6];

   enc_ctrl dut (
      .clk     (clk),
      .xrst    (xrst),
      .i_data  (i_data),
      .i_val   (i_val),
      .o_rdy   (o_rdy),
      .o_data  (o_data),
      .o_val   (o_val),
      .i_ack   (i_ack),
      .o_count (o_count)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] hrow(input int j);
      logic [15:0] hm;
      hm = 16'h9C63;
      return hm[j*4 +: 4];
   endfunction

   function automatic logic [7:0] enc(input logic [3:0] m);
      logic [3:0] p;
      logic       acc;
      acc = 1'b0;
      p   = '0;
      for (int j = 0; j < 4; j++) begin
         acc  = acc ^ (^(m & hrow(j)));
         p[j] = acc;
      end
      return {p, m};
   endfunction

   function automatic logic syn_ok(input logic [7:0] c);
      logic ok;
      logic pm;
      ok = 1'b1;
      for (int j = 0; j < 4; j++) begin
         pm = (j == 0) ? 1'b0 : c[4+j-1];
         if ((^(c[3:0] & hrow(j))) ^ c[4+j] ^ pm) ok = 1'b0;
      end
      return ok;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_val(output int n);
      n = 0;
      while (!o_val && n < 20) begin
         step();
         n++;
      end
      if (!o_val) chk("o_val_timeout", 32'(o_val), 32'd1);
   endtask

   task automatic send(input logic [3:0] d);
      int n;
      n = 0;
      while (!o_rdy && n < 20) begin
         step();
         n++;
      end
      if (!o_rdy) begin
         chk("o_rdy_timeout", 32'(o_rdy), 32'd1);
         return;
      end
      i_data = d;
      i_val  = 1'b1;
      step();
      i_val  = 1'b0;
      sb.push_back(enc(d));
      chk("accept_rdy_low", 32'(o_rdy), 32'd0);
   endtask

   task automatic recv();
      int n;
      logic [7:0] e;
      wait_val(n);
      if (!o_val) return;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'(o_data), 32'hffff);
         return;
      end
      e = sb.pop_front();
      chk("o_data", 32'(o_data), 32'(e));
      i_ack = 1'b1;
      step();
      i_ack = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      chk("o_count_after_ack", 32'(o_count), 32'(exp_cnt));
      chk("o_rdy_after_ack", 32'(o_rdy), 32'd1);
   endtask

   initial begin
      int n;
      logic [7:0] e;
      logic [3:0] d;

      tbl[0] = '{4'b0101, 8'h55};
      tbl[1] = '{4'b0001, 8'h71};
      tbl[2] = '{4'b1111, 8'h0F};
      tbl[3] = '{4'b0000, 8'h00};
      tbl[4] = '{4'b0010, 8'h12};
      tbl[5] = '{4'b1000, 8'h48};

      xrst   = 1'b0;
      i_data = 4'h0;
      i_val  = 1'b0;
      i_ack  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_o_rdy", 32'(o_rdy), 32'd1);
      chk("rst_o_val", 32'(o_val), 32'd0);
      chk("rst_o_data", 32'(o_data), 32'd0);
      chk("rst_o_count", 32'(o_count), 32'd0);
      xrst = 1'b1;

      // The accepting edge is the first of CHECK_NUM+1 edges to DONE.
      foreach (tbl[k]) begin
         send(tbl[k].data);
         wait_val(n);
         chk("latency_edges", 32'(n), 32'd4);
         chk("tbl_code", 32'(o_data), 32'(tbl[k].code));
         recv();
      end

      // i_val held high through CALC/DONE; ack and i_val coincide.
      i_data = 4'b0101;
      i_val  = 1'b1;
      step();
      sb.push_back(enc(4'b0101));
      i_data = 4'b1111;
      wait_val(n);
      e = sb.pop_front();
      chk("ignored_val_data", 32'(o_data), 32'(e));
      i_ack = 1'b1;
      step();
      i_ack = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      chk("ack_val_same_rdy", 32'(o_rdy), 32'd1);
      chk("ack_val_same_cnt", 32'(o_count), 32'(exp_cnt));
      step();
      i_val = 1'b0;
      chk("next_idle_accept", 32'(o_rdy), 32'd0);
      sb.push_back(enc(4'b1111));
      recv();

      // i_ack during CALC is ignored; then a 20-cycle hold in DONE.
      send(4'b0110);
      i_ack = 1'b1;
      step();
      step();
      i_ack = 1'b0;
      chk("ack_in_calc_cnt", 32'(o_count), 32'(exp_cnt));
      wait_val(n);
      e = sb[0];
      for (int c = 0; c < 20; c++) begin
         chk("hold_val", 32'(o_val), 32'd1);
         chk("hold_data", 32'(o_data), 32'(e));
         chk("hold_cnt", 32'(o_count), 32'(exp_cnt));
         step();
      end
      recv();

      // Reset on the second CALC cycle aborts the word.
      send(4'b1011);
      step();
      #2;
      xrst = 1'b0;
      #1;
      chk("abort_rdy", 32'(o_rdy), 32'd1);
      chk("abort_val", 32'(o_val), 32'd0);
      chk("abort_cnt", 32'(o_count), 32'd0);
      #3;
      xrst = 1'b1;
      sb.delete();
      exp_cnt = 8'd0;
      send(4'b0001);
      recv();

      // Fresh reset so the 256-word run starts the counter at 0.
      @(negedge clk);
      xrst = 1'b0;
      @(negedge clk);
      xrst = 1'b1;
      exp_cnt = 8'd0;
      chk("rst2_cnt", 32'(o_count), 32'd0);
      for (int w = 0; w < 256; w++) begin
         d = 4'($urandom_range(0, 15));
         send(d);
         wait_val(n);
         chk("syndrome", 32'(syn_ok(o_data)), 32'd1);
         recv();
      end
      chk("wrap_cnt", 32'(o_count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
